// File: rtl/systolic_mac_pe_pkg.sv
// Shared defaults and the saturating-narrow helper for the systolic MAC processing element.
package systolic_mac_pe_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_FRAC_W  = 10;
  localparam int unsigned DEF_GUARD_W = 8;

  // Works on a 64-bit signed carrier so one function serves any ACC_W/DATA_W pair up to 64 bits.
  function automatic logic signed [63:0] sat_narrow_fn(
    input logic signed [63:0] v,
    input int unsigned        out_w,
    input bit                 sat_en
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    sat_narrow_fn = v;
    if (sat_en) begin
      if (v > hi) begin
        sat_narrow_fn = hi;
      end else if (v < lo) begin
        sat_narrow_fn = lo;
      end
    end
  endfunction

endpackage

// File: rtl/systolic_mac_pe_sat_narrow.sv
// Combinational ACC_W -> DATA_W narrowing: clamp when SAT_EN, else keep the low DATA_W bits.
module systolic_mac_pe_sat_narrow
  import systolic_mac_pe_pkg::*;
#(
  parameter int unsigned ACC_W  = DEF_DATA_W + DEF_GUARD_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] narrow_c_o
);

  logic signed [63:0] wide;

  assign wide       = 64'($signed(acc_i));
  assign narrow_c_o = DATA_W'(sat_narrow_fn(wide, DATA_W, SAT_EN));

endmodule

// File: rtl/systolic_mac_pe.sv
// Weight-agnostic systolic PE: forwards west/north operands, accumulates fixed-point products,
// and hands finished tiles to a shift-out drain chain while the next tile accumulates.
module systolic_mac_pe
  import systolic_mac_pe_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FRAC_W  = DEF_FRAC_W,
  parameter int unsigned GUARD_W = DEF_GUARD_W,
  parameter bit          SAT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_en,
  input  logic [DATA_W-1:0] in_kiri,
  input  logic              in_kiri_vld,
  input  logic [DATA_W-1:0] in_atas,
  input  logic              in_atas_vld,
  output logic [DATA_W-1:0] out_kanan,
  output logic              out_kanan_vld,
  output logic [DATA_W-1:0] out_bawah,
  output logic              out_bawah_vld,
  input  logic              acc_clr,
  input  logic              drain_load,
  input  logic              drain_shift,
  input  logic [DATA_W-1:0] drain_in,
  output logic [DATA_W-1:0] drain_out,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam int unsigned ACC_W  = DATA_W + GUARD_W;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] drain_q, drain_d;
  logic [DATA_W-1:0] kanan_q, bawah_q;
  logic              kanan_vld_q, bawah_vld_q;

  logic                     mac_fire;
  logic                     restart;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;
  logic [ACC_W-1:0]         term;
  logic [ACC_W-1:0]         base;
  logic [SUM_W-1:0]         sum;
  logic                     sum_ovf;
  logic [DATA_W-1:0]        acc_narrow;

  assign mac_fire = in_kiri_vld & in_atas_vld;
  assign restart  = acc_clr | drain_load;

  // Q-format product rescaled back to FRAC_W fractional bits, then sign-extended to ACC_W.
  assign prod    = PROD_W'($signed(in_kiri)) * PROD_W'($signed(in_atas));
  assign prod_sh = prod >>> FRAC_W;
  assign term    = ACC_W'(prod_sh);

  // Clear-then-accumulate: a restart in the same cycle as a MAC starts the new tile from zero.
  assign base    = restart ? '0 : acc_q;
  assign sum     = {base[ACC_W-1], base} + {term[ACC_W-1], term};
  assign sum_ovf = sum[SUM_W-1] ^ sum[ACC_W-1];

  // One narrowing serves both the live result and the drain capture, both sourced from acc_q.
  systolic_mac_pe_sat_narrow #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SAT_EN (SAT_EN)
  ) u_sat_narrow (
    .acc_i      (acc_q),
    .narrow_c_o (acc_narrow)
  );

  always_comb begin
    acc_d   = base;
    ovf_d   = restart ? 1'b0 : ovf_q;
    drain_d = drain_q;
    if (mac_fire) begin
      if (sum_ovf) begin
        acc_d = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
    if (drain_load) begin
      drain_d = acc_narrow;
    end else if (drain_shift) begin
      drain_d = drain_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      drain_q     <= '0;
      kanan_q     <= '0;
      kanan_vld_q <= 1'b0;
      bawah_q     <= '0;
      bawah_vld_q <= 1'b0;
    end else if (pe_en) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      drain_q     <= drain_d;
      kanan_q     <= in_kiri;
      kanan_vld_q <= in_kiri_vld;
      bawah_q     <= in_atas;
      bawah_vld_q <= in_atas_vld;
    end
  end

  assign out_kanan     = kanan_q;
  assign out_kanan_vld = kanan_vld_q;
  assign out_bawah     = bawah_q;
  assign out_bawah_vld = bawah_vld_q;
  assign drain_out     = drain_q;
  assign result        = acc_narrow;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: saturating and truncating instances share stimulus, checked
// against directed expectations and an arithmetic reference model under random traffic.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst, pe_en, kv, av, acc_clr, drain_load, drain_shift;
  logic [15:0] k, a, drain_in;

  logic [15:0] ok_s, ob_s, dr_s, res_s, ok_t, ob_t, dr_t, res_t;
  logic        okv_s, obv_s, ovf_s, okv_t, obv_t, ovf_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: accumulator as a plain integer, narrowed per flavour on demand.
  longint      m_acc;
  bit          m_ovf;
  logic [15:0] m_drain_s, m_drain_t, m_ok, m_ob;
  bit          m_okv, m_obv;

  localparam longint ACC_HI = 64'sd8388607;
  localparam longint ACC_LO = -64'sd8388608;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(16), .FRAC_W(10), .GUARD_W(8), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .pe_en(pe_en),
    .in_kiri(k), .in_kiri_vld(kv), .in_atas(a), .in_atas_vld(av),
    .out_kanan(ok_s), .out_kanan_vld(okv_s), .out_bawah(ob_s), .out_bawah_vld(obv_s),
    .acc_clr(acc_clr), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in), .drain_out(dr_s), .result(res_s), .ovf(ovf_s)
  );

  systolic_mac_pe #(.DATA_W(16), .FRAC_W(10), .GUARD_W(8), .SAT_EN(1'b0)) dut_t (
    .clk(clk), .rst(rst), .pe_en(pe_en),
    .in_kiri(k), .in_kiri_vld(kv), .in_atas(a), .in_atas_vld(av),
    .out_kanan(ok_t), .out_kanan_vld(okv_t), .out_bawah(ob_t), .out_bawah_vld(obv_t),
    .acc_clr(acc_clr), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in), .drain_out(dr_t), .result(res_t), .ovf(ovf_t)
  );

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [15:0] trn16(input longint v);
    return 16'(v);
  endfunction

  function automatic longint sx16(input logic [15:0] x);
    return longint'(shortint'(x));
  endfunction

  task automatic model_edge();
    longint s;
    if (!rst) begin
      m_acc = 0; m_ovf = 0; m_drain_s = '0; m_drain_t = '0;
      m_ok = '0; m_ob = '0; m_okv = 0; m_obv = 0;
    end else if (pe_en) begin
      if (drain_load) begin
        m_drain_s = sat16(m_acc);
        m_drain_t = trn16(m_acc);
      end else if (drain_shift) begin
        m_drain_s = drain_in;
        m_drain_t = drain_in;
      end
      if (acc_clr || drain_load) begin
        m_acc = 0;
        m_ovf = 0;
      end
      if (kv && av) begin
        s = m_acc + ((sx16(k) * sx16(a)) >>> 10);
        if (s > ACC_HI) begin s = ACC_HI; m_ovf = 1; end
        if (s < ACC_LO) begin s = ACC_LO; m_ovf = 1; end
        m_acc = s;
      end
      m_ok = k; m_okv = kv; m_ob = a; m_obv = av;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    kv = 0; av = 0; k = '0; a = '0;
    acc_clr = 0; drain_load = 0; drain_shift = 0; drain_in = '0;
  endtask

  task automatic test_reset();
    rst = 0; pe_en = 1; set_idle();
    kv = 1; av = 1; k = 16'h1111; a = 16'h2222;
    cycle();
    n_tests++; if (res_s !== 16'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", res_s); end
    n_tests++; if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_s); end
    n_tests++; if ({okv_s, obv_s} !== 2'b00) begin n_fail++; $display("FAIL reset_vld got=%b exp=00", {okv_s, obv_s}); end
    n_tests++; if ({ok_s, ob_s, dr_s} !== 48'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {ok_s, ob_s, dr_s}); end
    rst = 1; set_idle();
  endtask

  task automatic test_mac_chain();
    kv = 1; av = 1; k = 16'h0400; a = 16'h0800;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_tests++; if (res_s !== 16'(16'h0800 * i)) begin n_fail++; $display("FAIL chain_result[%0d] got=%h exp=%h", i, res_s, 16'(16'h0800 * i)); end
    end
    n_tests++; if ({okv_s, ok_s} !== {1'b1, 16'h0400}) begin n_fail++; $display("FAIL chain_kanan got=%h exp=10400", {okv_s, ok_s}); end
    n_tests++; if ({obv_s, ob_s} !== {1'b1, 16'h0800}) begin n_fail++; $display("FAIL chain_bawah got=%h exp=10800", {obv_s, ob_s}); end
    set_idle();
    cycle();
    n_tests++; if (res_s !== 16'h1800) begin n_fail++; $display("FAIL chain_hold got=%h exp=1800", res_s); end
  endtask

  task automatic test_negative();
    set_idle(); acc_clr = 1;
    cycle();
    set_idle(); kv = 1; av = 1; k = 16'hFC00; a = 16'h0400;
    cycle();
    n_tests++; if (res_s !== 16'hFC00) begin n_fail++; $display("FAIL neg_result got=%h exp=fc00", res_s); end
    av = 0;
    cycle();
    n_tests++; if (res_s !== 16'hFC00) begin n_fail++; $display("FAIL neg_single_valid got=%h exp=fc00", res_s); end
    n_tests++; if ({okv_s, obv_s} !== 2'b10) begin n_fail++; $display("FAIL neg_fwd_vld got=%b exp=10", {okv_s, obv_s}); end
  endtask

  task automatic test_narrow_overflow();
    set_idle(); acc_clr = 1;
    cycle();
    set_idle(); kv = 1; av = 1; k = 16'h7C00; a = 16'h7C00;
    cycle();
    n_tests++; if (res_s !== 16'h7FFF) begin n_fail++; $display("FAIL narrow_sat got=%h exp=7fff", res_s); end
    n_tests++; if (res_t !== 16'h0400) begin n_fail++; $display("FAIL narrow_trunc got=%h exp=0400", res_t); end
    n_tests++; if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL narrow_ovf got=%b exp=0", ovf_s); end
    for (int i = 2; i <= 9; i++) begin
      cycle();
      if (i == 8) begin
        n_tests++; if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", ovf_s); end
      end
    end
    n_tests++; if ({ovf_s, ovf_t} !== 2'b11) begin n_fail++; $display("FAIL ovf_set got=%b exp=11", {ovf_s, ovf_t}); end
    n_tests++; if (res_t !== 16'hFFFF) begin n_fail++; $display("FAIL ovf_clamp_low got=%h exp=ffff", res_t); end
    set_idle(); drain_load = 1;
    cycle();
    n_tests++; if (dr_s !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_drain got=%h exp=7fff", dr_s); end
    n_tests++; if ({ovf_s, res_s} !== 17'h0) begin n_fail++; $display("FAIL ovf_cleared got=%h exp=0", {ovf_s, res_s}); end
  endtask

  task automatic test_drain();
    set_idle(); acc_clr = 1;
    cycle();
    set_idle(); kv = 1; av = 1; k = 16'h0400; a = 16'h0800;
    repeat (3) cycle();
    a = 16'h0400; drain_load = 1; drain_shift = 1; drain_in = 16'hBEEF;
    cycle();
    n_tests++; if (dr_s !== 16'h1800) begin n_fail++; $display("FAIL drain_load got=%h exp=1800", dr_s); end
    n_tests++; if (res_s !== 16'h0400) begin n_fail++; $display("FAIL drain_restart got=%h exp=0400", res_s); end
    set_idle(); drain_shift = 1; drain_in = 16'h1234;
    cycle();
    n_tests++; if (dr_s !== 16'h1234) begin n_fail++; $display("FAIL drain_shift got=%h exp=1234", dr_s); end
    n_tests++; if (res_s !== 16'h0400) begin n_fail++; $display("FAIL drain_concurrent got=%h exp=0400", res_s); end
  endtask

  task automatic test_freeze_and_reset();
    set_idle(); pe_en = 0;
    for (int i = 0; i < 4; i++) begin
      kv = 1; av = 1; k = 16'($urandom); a = 16'($urandom);
      acc_clr = 1'($urandom); drain_shift = 1; drain_in = 16'($urandom);
      cycle();
      n_tests++;
      if ({res_s, dr_s, ok_s, okv_s, ob_s, obv_s, ovf_s} !== {16'h0400, 16'h1234, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL freeze[%0d] got=%h/%h/%h/%h", i, res_s, dr_s, ok_s, ob_s);
      end
    end
    pe_en = 1; set_idle(); drain_shift = 1; drain_in = 16'h5555; kv = 1; av = 1; k = 16'h0400; a = 16'h0400;
    rst = 0;
    cycle();
    n_tests++;
    if ({res_s, dr_s, ok_s, okv_s, ob_s, obv_s, ovf_s} !== 52'h0) begin
      n_fail++; $display("FAIL reset_mid_drain got=%h/%h/%h/%h", res_s, dr_s, ok_s, ob_s);
    end
    rst = 1;
    cycle();
    rst = 0; pe_en = 0;
    cycle();
    n_tests++; if ({res_s, dr_s, ok_s, okv_s} !== 49'h0) begin n_fail++; $display("FAIL reset_no_en got=%h/%h/%h", res_s, dr_s, ok_s); end
    rst = 1; pe_en = 1; set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pe_en       = ($urandom_range(0, 9) != 0);
      kv          = ($urandom_range(0, 3) != 0);
      av          = ($urandom_range(0, 3) != 0);
      k           = ($urandom_range(0, 3) == 0) ? 16'h7C00 : 16'($urandom);
      a           = ($urandom_range(0, 3) == 0) ? 16'h7C00 : 16'($urandom);
      acc_clr     = ($urandom_range(0, 19) == 0);
      drain_load  = ($urandom_range(0, 19) == 0);
      drain_shift = ($urandom_range(0, 4) == 0);
      drain_in    = 16'($urandom);
      cycle();
      n_tests++;
      if ({res_s, res_t, ovf_s, ovf_t} !== {sat16(m_acc), trn16(m_acc), m_ovf, m_ovf}) begin
        n_fail++; $display("FAIL rand_acc[%0d] got=%h/%h/%b exp=%h/%h/%b", i, res_s, res_t, ovf_s, sat16(m_acc), trn16(m_acc), m_ovf);
      end
      n_tests++;
      if ({dr_s, dr_t} !== {m_drain_s, m_drain_t}) begin
        n_fail++; $display("FAIL rand_drain[%0d] got=%h/%h exp=%h/%h", i, dr_s, dr_t, m_drain_s, m_drain_t);
      end
      n_tests++;
      if ({ok_s, okv_s, ob_s, obv_s} !== {m_ok, m_okv, m_ob, m_obv}) begin
        n_fail++; $display("FAIL rand_fwd[%0d] got=%h/%b/%h/%b exp=%h/%b/%h/%b", i, ok_s, okv_s, ob_s, obv_s, m_ok, m_okv, m_ob, m_obv);
      end
    end
    set_idle(); pe_en = 1;
  endtask

  initial begin
    test_reset();
    test_mac_chain();
    test_negative();
    test_narrow_overflow();
    test_drain();
    test_freeze_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
